// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage load/store unit and data memory.
// Single-outstanding valid/ack protocol: bus_req is held until one bus_ack strobe.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks alignment, drives one bus access at a time,
// stalls the pipeline while busy and formats load data for writeback (data_mem).
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_read_m,
  input  logic                      mem_write_m,
  input  logic [1:0]                size_m,
  input  logic                      unsigned_m,
  input  logic [31:0]               addr_m,
  input  logic [31:0]               wdata_m,
  output logic                      stall_m,
  output logic                      fault_m,
  output logic [31:0]               data_mem,
  output logic                      data_mem_valid,
  mem_access_unit_if.master         bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] data_mem_q, data_mem_d;
  logic        data_mem_valid_q, data_mem_valid_d;
  logic        fault_q, fault_d;
  // Load formatting info latched at request time so the bus phase does not
  // depend on the (held) pipeline inputs.
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        uns_q, uns_d;

  logic        req_any, legal, size_ok;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Request legality: one direction only, legal size, natural alignment.
  always_comb begin
    size_ok = 1'b0;
    case (size_m)
      2'b00:   size_ok = 1'b1;
      2'b01:   size_ok = ~addr_m[0];
      2'b10:   size_ok = (addr_m[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
    req_any = mem_read_m | mem_write_m;
    legal   = (mem_read_m ^ mem_write_m) & size_ok;
  end

  // Store lane replication and byte enables.
  always_comb begin
    st_wdata = wdata_m;
    st_be    = 4'b1111;
    case (size_m)
      2'b00: begin
        st_wdata = {4{wdata_m[7:0]}};
        st_be    = 4'b0001 << addr_m[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_m[15:0]}};
        st_be    = addr_m[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = wdata_m;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    ld_byte = bus.bus_rdata[7:0];
    case (lane_q)
      2'd0:    ld_byte = bus.bus_rdata[7:0];
      2'd1:    ld_byte = bus.bus_rdata[15:8];
      2'd2:    ld_byte = bus.bus_rdata[23:16];
      default: ld_byte = bus.bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (size_q)
      2'b00:   ld_fmt = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_fmt = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_fmt = bus.bus_rdata;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      bus_req_q        <= 1'b0;
      bus_we_q         <= 1'b0;
      bus_addr_q       <= '0;
      bus_wdata_q      <= '0;
      bus_be_q         <= '0;
      data_mem_q       <= '0;
      data_mem_valid_q <= 1'b0;
      fault_q          <= 1'b0;
      size_q           <= '0;
      lane_q           <= '0;
      uns_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bus_req_q        <= bus_req_d;
      bus_we_q         <= bus_we_d;
      bus_addr_q       <= bus_addr_d;
      bus_wdata_q      <= bus_wdata_d;
      bus_be_q         <= bus_be_d;
      data_mem_q       <= data_mem_d;
      data_mem_valid_q <= data_mem_valid_d;
      fault_q          <= fault_d;
      size_q           <= size_d;
      lane_q           <= lane_d;
      uns_q            <= uns_d;
    end
  end

  // Next-state: IDLE -> BUS -> DONE -> IDLE, with ack or timeout ending BUS.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bus_req_d        = bus_req_q;
    bus_we_d         = bus_we_q;
    bus_addr_d       = bus_addr_q;
    bus_wdata_d      = bus_wdata_q;
    bus_be_d         = bus_be_q;
    data_mem_d       = data_mem_q;
    data_mem_valid_d = 1'b0;
    fault_d          = 1'b0;
    size_d           = size_q;
    lane_d           = lane_q;
    uns_d            = uns_q;
    case (state_q)
      IDLE: begin
        if (legal) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write_m;
          bus_addr_d  = {addr_m[31:2], 2'b00};
          bus_wdata_d = st_wdata;
          bus_be_d    = mem_write_m ? st_be : 4'b1111;
          cnt_d       = '0;
          size_d      = size_m;
          lane_d      = addr_m[1:0];
          uns_d       = unsigned_m;
          state_d     = BUS;
        end
      end
      BUS: begin
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            data_mem_d       = ld_fmt;
            data_mem_valid_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: stall covers the request cycle combinationally; during reset
  // the combinational outputs are forced low alongside the cleared flops.
  always_comb begin
    stall_m = rst_n & (((state_q == IDLE) & legal) | (state_q == BUS));
    fault_m = rst_n & (((state_q == IDLE) & req_any & ~legal) | fault_q);
    data_mem       = data_mem_q;
    data_mem_valid = data_mem_valid_q;
    bus.bus_req    = bus_req_q;
    bus.bus_we     = bus_we_q;
    bus.bus_addr   = bus_addr_q;
    bus.bus_wdata  = bus_wdata_q;
    bus.bus_be     = bus_be_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, illegal requests,
// timeout and mid-access reset, with hand-computed expected values.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_m, mem_write_m, unsigned_m;
  logic [1:0]  size_m;
  logic [31:0] addr_m, wdata_m;
  logic        stall_m, fault_m, data_mem_valid;
  logic [31:0] data_mem;
  logic [31:0] dm_exp;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mem_access_unit_if bus_if();

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_m     (mem_read_m),
    .mem_write_m    (mem_write_m),
    .size_m         (size_m),
    .unsigned_m     (unsigned_m),
    .addr_m         (addr_m),
    .wdata_m        (wdata_m),
    .stall_m        (stall_m),
    .fault_m        (fault_m),
    .data_mem       (data_mem),
    .data_mem_valid (data_mem_valid),
    .bus            (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    mem_read_m  = 1'b0;
    mem_write_m = 1'b0;
    size_m      = 2'b00;
    unsigned_m  = 1'b0;
    addr_m      = '0;
    wdata_m     = '0;
  endtask

  // One legal access; ack arrives in BUS cycle number wait_cyc (0 = first).
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] rdat, input int unsigned wait_cyc,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_dm);
    @(negedge clk);
    mem_read_m = rd; mem_write_m = wr; size_m = sz; unsigned_m = un;
    addr_m = ad; wdata_m = wd;
    #1;
    chk({tag, "_req_stall"}, 32'(stall_m), 32'd1);
    chk({tag, "_req_fault"}, 32'(fault_m), 32'd0);
    for (int unsigned i = 0; i <= wait_cyc; i++) begin
      @(negedge clk);
      if (i == wait_cyc) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = rdat;
      end
      #1;
      chk({tag, "_bus_req"},   32'(bus_if.bus_req), 32'd1);
      chk({tag, "_bus_stall"}, 32'(stall_m), 32'd1);
    end
    chk({tag, "_bus_we"},   32'(bus_if.bus_we), 32'(wr));
    chk({tag, "_bus_addr"}, bus_if.bus_addr, {ad[31:2], 2'b00});
    chk({tag, "_bus_be"},   32'(bus_if.bus_be), 32'(exp_be));
    if (wr) chk({tag, "_bus_wdata"}, bus_if.bus_wdata, exp_wdata);
    @(negedge clk);
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h5A5A_5A5A;
    #1;
    chk({tag, "_done_stall"}, 32'(stall_m), 32'd0);
    chk({tag, "_done_req"},   32'(bus_if.bus_req), 32'd0);
    chk({tag, "_done_valid"}, 32'(data_mem_valid), 32'(rd));
    chk({tag, "_done_dm"},    data_mem, exp_dm);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_idle_valid"}, 32'(data_mem_valid), 32'd0);
    chk({tag, "_idle_stall"}, 32'(stall_m), 32'd0);
    chk({tag, "_idle_fault"}, 32'(fault_m), 32'd0);
    chk({tag, "_idle_dm"},    data_mem, exp_dm);
  endtask

  // Illegal request: single fault pulse, no stall, no bus activity.
  task automatic illegal(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] ad);
    @(negedge clk);
    mem_read_m = rd; mem_write_m = wr; size_m = sz; addr_m = ad;
    wdata_m = 32'h1111_2222;
    #1;
    chk({tag, "_fault"}, 32'(fault_m), 32'd1);
    chk({tag, "_stall"}, 32'(stall_m), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk({tag, "_fault_off"}, 32'(fault_m), 32'd0);
    chk({tag, "_no_req"},    32'(bus_if.bus_req), 32'd0);
    chk({tag, "_dm"},        data_mem, dm_exp);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    #12;
    chk("rst_req",   32'(bus_if.bus_req), 32'd0);
    chk("rst_addr",  bus_if.bus_addr, 32'd0);
    chk("rst_be",    32'(bus_if.bus_be), 32'd0);
    chk("rst_dm",    data_mem, 32'd0);
    chk("rst_valid", 32'(data_mem_valid), 32'd0);
    chk("rst_stall", 32'(stall_m), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loads
    access("ldw",  1, 0, 2'b10, 0, 32'h100, 32'h0, 32'h1234_5678, 2, 4'hF, 32'h0, 32'h1234_5678);
    access("ldbs", 1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80FF_7F01, 0, 4'hF, 32'h0, 32'hFFFF_FF80);
    access("ldbu", 1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80FF_7F01, 1, 4'hF, 32'h0, 32'h0000_0080);
    access("ldhs", 1, 0, 2'b01, 0, 32'h202, 32'h0, 32'h80FF_7F01, 0, 4'hF, 32'h0, 32'hFFFF_80FF);
    access("ldb1", 1, 0, 2'b00, 0, 32'h201, 32'h0, 32'h80FF_7F01, 0, 4'hF, 32'h0, 32'h0000_007F);
    dm_exp = 32'h0000_007F;

    // Stores: data_mem keeps the last load result
    access("stb", 0, 1, 2'b00, 0, 32'h301, 32'h1234_56A5, 32'h0, 1, 4'b0010, 32'hA5A5_A5A5, dm_exp);
    access("sth", 0, 1, 2'b01, 0, 32'h302, 32'hDEAD_BEEF, 32'h0, 0, 4'b1100, 32'hBEEF_BEEF, dm_exp);
    access("stw", 0, 1, 2'b10, 0, 32'h400, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, dm_exp);

    // Illegal requests
    illegal("ill_w102", 1, 0, 2'b10, 32'h102);
    illegal("ill_h101", 1, 0, 2'b01, 32'h101);
    illegal("ill_sz11", 1, 0, 2'b11, 32'h100);
    illegal("ill_rw",   1, 1, 2'b10, 32'h100);

    // Timeout: 8 BUS cycles with no ack
    @(negedge clk);
    mem_read_m = 1'b1; size_m = 2'b10; addr_m = 32'h500;
    #1;
    chk("to_req_stall", 32'(stall_m), 32'd1);
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      chk("to_bus_req",   32'(bus_if.bus_req), 32'd1);
      chk("to_bus_fault", 32'(fault_m), 32'd0);
    end
    @(negedge clk);
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'hDEAD_DEAD;
    #1;
    chk("to_done_req",   32'(bus_if.bus_req), 32'd0);
    chk("to_done_fault", 32'(fault_m), 32'd1);
    chk("to_done_stall", 32'(stall_m), 32'd0);
    chk("to_done_valid", 32'(data_mem_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("to_idle_fault", 32'(fault_m), 32'd0);
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("to_late_valid", 32'(data_mem_valid), 32'd0);
    chk("to_late_dm",    data_mem, dm_exp);
    chk("to_late_req",   32'(bus_if.bus_req), 32'd0);

    // Reset in the middle of BUS
    @(negedge clk);
    mem_read_m = 1'b1; size_m = 2'b10; addr_m = 32'h600;
    @(negedge clk); #1;
    chk("rb_req", 32'(bus_if.bus_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_req_drop",   32'(bus_if.bus_req), 32'd0);
    chk("rb_stall_drop", 32'(stall_m), 32'd0);
    chk("rb_dm_clr",     data_mem, 32'd0);
    dm_exp = '0;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    bus_if.bus_ack   = 1'b1;
    bus_if.bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    chk("rb_ack_valid", 32'(data_mem_valid), 32'd0);
    chk("rb_ack_dm",    data_mem, dm_exp);
    access("rb_ldhu", 1, 0, 2'b01, 1, 32'h602, 32'h0, 32'hABCD_1234, 0, 4'hF, 32'h0, 32'h0000_ABCD);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
